// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   state_t : arbiter FSM encoding (IDLE may accept, RD_WAIT read outstanding)
//   REQ_IF  : requester ID of the fetch port
//   REQ_LS  : requester ID of the load/store port
package mem_arb_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/rr_pick2.sv
// Two-input round-robin pick.
//   req      in  [1:0] : request vector, bit index = requester ID
//   last_gnt in        : ID of the requester granted most recently
//   gnt      out [1:0] : one-hot grant (all zero when nothing requests)
// A lone requester always wins; on a tie the requester that was not granted
// last time wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   // Combinational grant decision
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            if (last_gnt == REQ_LS) begin
               gnt = 2'b01;
            end else begin
               gnt = 2'b10;
            end
         end
         default: gnt = 2'b00;
      endcase
   end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-cycle-latency memory between a fetch requester
// (read only) and a load/store requester.
//   clk, reset                         : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid : fetch request / accept / data valid
//   ls_req/ls_we/ls_addr/ls_wdata
//      -> ls_gnt/ls_rvalid             : load/store request / accept / data valid
//   rdata                              : read data, qualified by *_rvalid
//   mem_en/mem_we/mem_addr/mem_wdata   : memory command
//   mem_rdata                          : memory data, one cycle after a read
// Grants are combinational in IDLE; a read costs one extra RD_WAIT cycle in
// which the memory data is returned to the owner and nothing is accepted.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_gnt,
   output logic          ls_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   state_t     state_r;
   state_t     state_next_s;
   logic       last_gnt_r;
   logic       owner_r;
   logic [1:0] pick_s;
   logic       grant_s;
   logic       win_s;
   logic       read_s;

   rr_pick2 u_pick (
      .req      ({ls_req, if_req}),
      .last_gnt (last_gnt_r),
      .gnt      (pick_s)
   );

   // Next-state and output decode; reset masks every strobe
   always_comb begin
      state_next_s = ST_IDLE;
      grant_s      = 1'b0;
      win_s        = REQ_IF;
      read_s       = 1'b0;
      if_gnt       = 1'b0;
      ls_gnt       = 1'b0;
      if_rvalid    = 1'b0;
      ls_rvalid    = 1'b0;
      rdata        = {DW{1'b0}};
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = {AW{1'b0}};
      mem_wdata    = {DW{1'b0}};
      if (reset) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_s != 2'b00) begin
                  grant_s = 1'b1;
                  mem_en  = 1'b1;
                  if (pick_s[1]) begin
                     win_s     = REQ_LS;
                     ls_gnt    = 1'b1;
                     mem_we    = ls_we;
                     mem_addr  = ls_addr;
                     mem_wdata = ls_wdata;
                     read_s    = ~ls_we;
                  end else begin
                     // Fetch is always a read with zero write data
                     win_s     = REQ_IF;
                     if_gnt    = 1'b1;
                     mem_addr  = if_addr;
                     read_s    = 1'b1;
                  end
               end else begin
                  grant_s = 1'b0;
               end
               state_next_s = read_s ? ST_RD_WAIT : ST_IDLE;
            end
            ST_RD_WAIT: begin
               rdata = mem_rdata;
               if (owner_r == REQ_LS) begin
                  ls_rvalid = 1'b1;
               end else begin
                  if_rvalid = 1'b1;
               end
               state_next_s = ST_IDLE;
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, fairness pointer and read owner
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         last_gnt_r <= REQ_LS;
         owner_r    <= REQ_IF;
      end else begin
         state_r <= state_next_s;
         if (grant_s) begin
            last_gnt_r <= win_s;
         end
         if (grant_s && read_s) begin
            owner_r <= win_s;
         end
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after the rising edge; combinational outputs are sampled 1 unit later.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic        mem_en, mem_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // advance to the next cycle's drive point
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
      if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h55;
      next_cycle(); next_cycle(); settle();
      checks++; if ({if_gnt, ls_gnt, mem_en} !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", {if_gnt, ls_gnt, mem_en}); end
      checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, ls_rvalid}); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      next_cycle();
      reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;
   endtask

   task automatic test_tie_read();
      next_cycle();
      if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; ls_wdata = 32'h12345678;
      settle();
      checks++; if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010) begin errors++; $display("FAIL tie_c0_strobes: got %b want 1010", {if_gnt, ls_gnt, mem_en, mem_we}); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL tie_c0_addr: got %h want 10", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL tie_c0_wdata: got %h want 0", mem_wdata); end
      next_cycle();
      if_req = 1'b0; mem_rdata = 32'hA1A1A1A1;
      settle();
      checks++; if ({if_rvalid, ls_rvalid, ls_gnt, mem_en} !== 4'b1000) begin errors++; $display("FAIL tie_c1_strobes: got %b want 1000", {if_rvalid, ls_rvalid, ls_gnt, mem_en}); end
      checks++; if (rdata !== 32'hA1A1A1A1) begin errors++; $display("FAIL tie_c1_rdata: got %h want a1a1a1a1", rdata); end
      next_cycle();
      settle();
      checks++; if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1010) begin errors++; $display("FAIL tie_c2_strobes: got %b want 1010", {ls_gnt, if_gnt, mem_en, mem_we}); end
      checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL tie_c2_addr: got %h want 20", mem_addr); end
      next_cycle();
      ls_req = 1'b0; mem_rdata = 32'hB2B2B2B2;
      settle();
      checks++; if ({ls_rvalid, if_rvalid} !== 2'b10) begin errors++; $display("FAIL tie_c3_rvalid: got %b want 10", {ls_rvalid, if_rvalid}); end
      checks++; if (rdata !== 32'hB2B2B2B2) begin errors++; $display("FAIL tie_c3_rdata: got %h want b2b2b2b2", rdata); end
   endtask

   task automatic test_write();
      next_cycle();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h44; ls_wdata = 32'hDEADBEEF; mem_rdata = 32'h77;
      settle();
      checks++; if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1011) begin errors++; $display("FAIL wr_strobes: got %b want 1011", {ls_gnt, if_gnt, mem_en, mem_we}); end
      checks++; if (mem_addr !== 32'h44 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_cmd: got %h/%h want 44/deadbeef", mem_addr, mem_wdata); end
      next_cycle();
      ls_req = 1'b0; ls_we = 1'b0;
      settle();
      checks++; if ({ls_rvalid, if_rvalid, mem_en} !== 3'b000 || rdata !== 32'h0) begin errors++; $display("FAIL wr_after: got %b rdata %h want 000 rdata 0", {ls_rvalid, if_rvalid, mem_en}, rdata); end
   endtask

   // last grant before this test went to LS, so fetch wins first
   task automatic test_alternate();
      logic exp_ls;
      if_addr = 32'h100; ls_addr = 32'h200; ls_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_ls = (i % 2) == 1;
         next_cycle();
         if_req = 1'b1; ls_req = 1'b1;
         settle();
         checks++; if ({ls_gnt, if_gnt} !== {exp_ls, ~exp_ls}) begin errors++; $display("FAIL alt_gnt[%0d]: got ls/if %b want %b", i, {ls_gnt, if_gnt}, {exp_ls, ~exp_ls}); end
         checks++; if (mem_addr !== (exp_ls ? 32'h200 : 32'h100)) begin errors++; $display("FAIL alt_addr[%0d]: got %h", i, mem_addr); end
         next_cycle();
         mem_rdata = 32'hC000_0000 + 32'(i);
         settle();
         checks++; if ({ls_rvalid, if_rvalid} !== {exp_ls, ~exp_ls} || rdata !== 32'hC000_0000 + 32'(i)) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b rdata %h", i, {ls_rvalid, if_rvalid}, rdata); end
      end
      if_req = 1'b0; ls_req = 1'b0;
   endtask

   task automatic test_rd_wait_block();
      next_cycle();
      if_req = 1'b1; if_addr = 32'h30;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rdw_if_gnt: got %b want 1", if_gnt); end
      next_cycle();
      if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h34; mem_rdata = 32'h0D0D;
      settle();
      checks++; if ({ls_gnt, mem_en, if_rvalid} !== 3'b001) begin errors++; $display("FAIL rdw_block: got %b want 001", {ls_gnt, mem_en, if_rvalid}); end
      next_cycle();
      settle();
      checks++; if ({ls_gnt, mem_en} !== 2'b11 || mem_addr !== 32'h34) begin errors++; $display("FAIL rdw_ls_gnt: got %b addr %h want 11 addr 34", {ls_gnt, mem_en}, mem_addr); end
      next_cycle();
      ls_req = 1'b0;
   endtask

   task automatic test_reset_in_rd_wait();
      next_cycle();
      if_req = 1'b1; if_addr = 32'h50;
      settle();
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rst_rdw_gnt: got %b want 1", if_gnt); end
      next_cycle();
      if_req = 1'b0; reset = 1'b1; mem_rdata = 32'hBAD0BAD0;
      settle();
      checks++; if ({if_rvalid, ls_rvalid, mem_en} !== 3'b000) begin errors++; $display("FAIL rst_rdw_no_rvalid: got %b want 000", {if_rvalid, ls_rvalid, mem_en}); end
      next_cycle();
      reset = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h60;
      settle();
      checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_after_rvalid: got %b want 00", {if_rvalid, ls_rvalid}); end
      checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin errors++; $display("FAIL rst_after_tie: got if/ls %b want 10", {if_gnt, ls_gnt}); end
      next_cycle();
      if_req = 1'b0; ls_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80 + 32'(4 * i); ls_wdata = 32'h1111_0000 + 32'(i);
         settle();
         checks++; if ({ls_gnt, mem_en, mem_we} !== 3'b111) begin errors++; $display("FAIL b2b_strobes[%0d]: got %b want 111", i, {ls_gnt, mem_en, mem_we}); end
         checks++; if (mem_addr !== 32'h80 + 32'(4 * i) || mem_wdata !== 32'h1111_0000 + 32'(i)) begin errors++; $display("FAIL b2b_cmd[%0d]: got %h/%h", i, mem_addr, mem_wdata); end
      end
      next_cycle();
      ls_req = 1'b0; ls_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tie_read();
      test_write();
      test_alternate();
      test_rd_wait_block();
      test_reset_in_rd_wait();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width in bits.
REQ-002 Parameter DW, default 32: data width in bits.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port if_req  in  1: fetch requester (requester 0) read request.
REQ-006 Port if_addr  in  AW: fetch address.
REQ-007 Port if_gnt  out  1: fetch request accepted this cycle.
REQ-008 Port if_rvalid  out  1: fetch read data valid on rdata.
REQ-009 Port ls_req  in  1: load/store requester (requester 1) request.
REQ-010 Port ls_we  in  1: 1 = write, 0 = read.
REQ-011 Port ls_addr  in  AW; ls_wdata  in  DW: load/store address and write data.
REQ-012 Port ls_gnt  out  1; ls_rvalid  out  1: load/store accept and read-data valid.
REQ-013 Port rdata  out  DW: read data shared by both requesters, qualified by the *_rvalid strobes.
REQ-014 Port mem_en  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW: unified memory command.
REQ-015 Port mem_rdata  in  DW: memory read data, valid exactly one cycle after a read command.

Function
REQ-016 The block SHALL have two states: IDLE (may accept) and RD_WAIT (read outstanding).
REQ-017 In IDLE with at least one req high, exactly one gnt SHALL assert combinationally in the same cycle, and mem_en SHALL assert with the granted requester's command.
REQ-018 A single requester SHALL be granted immediately; when both request, the requester not granted most recently (last_gnt register) SHALL win.
REQ-019 if_req SHALL always be issued as a read (mem_we=0, mem_wdata=0).
REQ-020 A granted write SHALL complete in the grant cycle; state stays IDLE; no rvalid is produced.
REQ-021 A granted read SHALL move the state to RD_WAIT and record the owner.
REQ-022 In RD_WAIT, the owner's rvalid SHALL assert for exactly one cycle with rdata = mem_rdata; no gnt or mem_en SHALL assert; the next state is IDLE.
REQ-023 Read throughput SHALL be one read per 2 cycles; write throughput one write per cycle.
REQ-024 Outside RD_WAIT, rdata SHALL be 0 and both rvalid strobes 0.
REQ-025 Requesters SHALL hold req and command stable until gnt; a req dropped before gnt is discarded with no side effect.
REQ-026 With both requesters continuously requesting, grants SHALL alternate; no requester waits for more than one other transaction.
REQ-027 last_gnt SHALL update only on a grant.

Reset
REQ-028 When reset is high at a clock edge: state=IDLE, last_gnt=requester 1 (so fetch wins the first tie), owner=requester 0.
REQ-029 While reset is high, all gnt, rvalid and mem_en outputs SHALL be 0 regardless of req.
REQ-030 A reset arriving in RD_WAIT SHALL abandon the outstanding read; no rvalid SHALL follow.

Structure
REQ-031 The state encoding (IDLE, RD_WAIT) and requester IDs (REQ_IF=0, REQ_LS=1) SHALL reside in a shared package, mem_arb_pkg.
REQ-032 The grant decision SHALL be a sub-module rr_pick2 (two-input round-robin pick from req vector and last_gnt); all other logic sits in mem_arbiter.

Verification
REQ-033 After reset, both req high in the same cycle, if_addr=0x10, ls read 0x20 -> cycle 0: if_gnt, mem_addr=0x10; cycle 1: if_rvalid, rdata=mem_rdata; cycle 2: ls_gnt, mem_addr=0x20; cycle 3: ls_rvalid.
REQ-034 ls write 0x44 <- 0xDEADBEEF, if_req low -> ls_gnt, mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in the same cycle; next cycle IDLE, no rvalid.
REQ-035 Both requesters held high for 8 transactions (all reads) -> grants strictly alternate IF, LS, IF, LS, ...; each rvalid goes only to its owner.
REQ-036 ls_req asserted during an RD_WAIT cycle -> no ls_gnt that cycle; ls_gnt in the following IDLE cycle.
REQ-037 reset asserted in the RD_WAIT cycle -> no rvalid; next cycle IDLE; a subsequent tie is won by fetch.
REQ-038 Back-to-back ls writes with no fetch request -> ls_gnt every cycle, one mem_en write per cycle.
